// File: rtl/sdpb_pkg.sv
// rtl/sdpb_pkg.sv - shared constants for the semi-dual-port block RAM
package sdpb_pkg;

   localparam int SDPB_BYPASS   = 0;
   localparam int SDPB_PIPELINE = 1;

   localparam int SDPB_ADDR_W = 6;
   localparam int SDPB_DATA_W = 1;
   localparam int SDPB_DEPTH  = 64;

endpackage

// File: rtl/gowin_sdpb2_if.sv
// rtl/gowin_sdpb2_if.sv - write port A / read port B bundle for gowin_sdpb2
interface gowin_sdpb2_if
   import sdpb_pkg::*;
#(
   parameter int ADDR_W = SDPB_ADDR_W,
   parameter int DATA_W = SDPB_DATA_W
);

   logic              cea;
   logic [ADDR_W-1:0] ada;
   logic [DATA_W-1:0] din;
   logic              ceb;
   logic [ADDR_W-1:0] adb;
   logic              oce;
   logic [DATA_W-1:0] dout;

   modport master (
      output cea, ada, din, ceb, adb, oce,
      input  dout
   );

   modport slave (
      input  cea, ada, din, ceb, adb, oce,
      output dout
   );

endinterface

// File: rtl/sdpb_out_reg.sv
// rtl/sdpb_out_reg.sv - read-data register with synchronous reset and enable
module sdpb_out_reg #(
   parameter int                DATA_W      = 1,
   parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RESET_VALUE;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/gowin_sdpb2.sv
// rtl/gowin_sdpb2.sv - single-clock semi-dual-port block RAM, read-first on collision
module gowin_sdpb2
   import sdpb_pkg::*;
#(
   parameter int                ADDR_W      = SDPB_ADDR_W,
   parameter int                DATA_W      = SDPB_DATA_W,
   parameter int                DEPTH       = SDPB_DEPTH,
   parameter int                READ_MODE   = SDPB_BYPASS,
   parameter logic [DATA_W-1:0] INIT_VALUE  = '0,
   parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
   input logic          clk,
   input logic          reset,
   gowin_sdpb2_if.slave bus
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   if ((DEPTH > (2 ** ADDR_W)) || (DEPTH < 1) || (DATA_W < 1) ||
       ((READ_MODE != SDPB_BYPASS) && (READ_MODE != SDPB_PIPELINE))) begin : g_bad_cfg
      $error("gowin_sdpb2: illegal geometry or READ_MODE");
   end

   logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: INIT_VALUE};

   logic              wr_ok;
   logic              rd_ok;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rd_q;

   assign wr_ok = bus.cea && ({1'b0, bus.ada} < DEPTH_L);
   assign rd_ok = {1'b0, bus.adb} < DEPTH_L;

   // Reset only touches the output registers; the array keeps its contents.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[bus.ada] <= bus.din;
      end
   end

   // Sampling the array before this edge's write gives read-first collisions.
   assign rd_word = rd_ok ? mem[bus.adb] : '0;

   sdpb_out_reg #(
      .DATA_W      (DATA_W),
      .RESET_VALUE (RESET_VALUE)
   ) u_rd_q (
      .clk   (clk),
      .reset (reset),
      .en    (bus.ceb),
      .d     (rd_word),
      .q     (rd_q)
   );

   if (READ_MODE == SDPB_PIPELINE) begin : g_pipe
      logic [DATA_W-1:0] out_q;

      sdpb_out_reg #(
         .DATA_W      (DATA_W),
         .RESET_VALUE (RESET_VALUE)
      ) u_out_q (
         .clk   (clk),
         .reset (reset),
         .en    (bus.oce),
         .d     (rd_q),
         .q     (out_q)
      );

      assign bus.dout = out_q;
   end else begin : g_bypass
      assign bus.dout = rd_q;
   end

endmodule

// File: tb/tb_gowin_sdpb2.sv
// tb/tb_gowin_sdpb2.sv - bench for gowin_sdpb2 in bypass, pipeline and short-depth builds
module tb_gowin_sdpb2;

   logic       clk;
   logic       reset;
   logic       cea;
   logic [5:0] ada;
   logic       din;
   logic       ceb;
   logic [5:0] adb;
   logic       oce;

   int errors = 0;
   int checks = 0;

   gowin_sdpb2_if #(.ADDR_W(6), .DATA_W(1)) bus0 ();
   gowin_sdpb2_if #(.ADDR_W(6), .DATA_W(1)) bus1 ();
   gowin_sdpb2_if #(.ADDR_W(6), .DATA_W(1)) bus2 ();

   assign bus0.cea = cea;  assign bus1.cea = cea;  assign bus2.cea = cea;
   assign bus0.ada = ada;  assign bus1.ada = ada;  assign bus2.ada = ada;
   assign bus0.din = din;  assign bus1.din = din;  assign bus2.din = din;
   assign bus0.ceb = ceb;  assign bus1.ceb = ceb;  assign bus2.ceb = ceb;
   assign bus0.adb = adb;  assign bus1.adb = adb;  assign bus2.adb = adb;
   assign bus0.oce = oce;  assign bus1.oce = oce;  assign bus2.oce = oce;

   gowin_sdpb2 #(.ADDR_W(6), .DATA_W(1), .DEPTH(64), .READ_MODE(0)) u_byp (
      .clk(clk), .reset(reset), .bus(bus0.slave));
   gowin_sdpb2 #(.ADDR_W(6), .DATA_W(1), .DEPTH(64), .READ_MODE(1)) u_pipe (
      .clk(clk), .reset(reset), .bus(bus1.slave));
   gowin_sdpb2 #(.ADDR_W(6), .DATA_W(1), .DEPTH(36), .READ_MODE(0)) u_short (
      .clk(clk), .reset(reset), .bus(bus2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: word arrays plus the value each build should show at dout.
   logic m_mem [3][64];
   logic m_dout_byp [3];
   logic m_latched;
   logic m_out;
   int   depth [3] = '{64, 64, 36};

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic nxt [3];
      logic nxt_out;
      for (int i = 0; i < 3; i++) begin
         if (reset) nxt[i] = 1'b0;
         else if (ceb) nxt[i] = (int'(adb) < depth[i]) ? m_mem[i][adb] : 1'b0;
         else nxt[i] = m_dout_byp[i];
      end
      nxt_out = reset ? 1'b0 : (oce ? m_dout_byp[1] : m_out);
      for (int i = 0; i < 3; i++) begin
         if (cea && (int'(ada) < depth[i])) m_mem[i][ada] = din;
      end
      for (int i = 0; i < 3; i++) m_dout_byp[i] = nxt[i];
      m_out = nxt_out;
      @(posedge clk);
      #1;
      check("model_byp", bus0.dout, m_dout_byp[0]);
      check("model_pipe", bus1.dout, m_out);
      check("model_short", bus2.dout, m_dout_byp[2]);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         for (int a = 0; a < 64; a++) m_mem[i][a] = 1'b0;
         m_dout_byp[i] = 1'b0;
      end
      m_out = 1'b0;
      m_latched = 1'b0;
      reset = 1'b1; cea = 1'b0; ada = '0; din = 1'b0; ceb = 1'b0; adb = '0; oce = 1'b0;

      // reset state
      tick();
      tick();
      check("reset_byp", bus0.dout, 1'b0);
      check("reset_pipe", bus1.dout, 1'b0);
      reset = 1'b0;

      // write then read
      cea = 1'b1; ada = 6'd5; din = 1'b1;
      tick();
      cea = 1'b0;
      tick();
      ceb = 1'b1; adb = 6'd5;
      tick();
      check("wr_rd_5", bus0.dout, 1'b1);
      adb = 6'd6;
      tick();
      check("unwritten_6", bus0.dout, 1'b0);

      // collision is read-first
      cea = 1'b1; ada = 6'd10; din = 1'b0; ceb = 1'b0;
      tick();
      din = 1'b1; ceb = 1'b1; adb = 6'd10;
      tick();
      check("collide_old", bus0.dout, 1'b0);
      cea = 1'b0;
      tick();
      check("collide_new", bus0.dout, 1'b1);

      // pipeline latency and oce hold
      cea = 1'b1; ada = 6'd3; din = 1'b1; adb = 6'd6; oce = 1'b1;
      tick();
      cea = 1'b0;
      tick();
      check("pipe_pre", bus1.dout, 1'b0);
      adb = 6'd3;
      tick();
      check("pipe_lat1", bus1.dout, 1'b0);
      check("byp_lat1", bus0.dout, 1'b1);
      adb = 6'd6;
      tick();
      check("pipe_lat2", bus1.dout, 1'b1);
      oce = 1'b0;
      tick();
      check("pipe_hold1", bus1.dout, 1'b1);
      tick();
      check("pipe_hold2", bus1.dout, 1'b1);
      oce = 1'b1;
      tick();
      check("pipe_resume", bus1.dout, 1'b0);

      // reset mid-stream keeps memory
      cea = 1'b1; din = 1'b1; ceb = 1'b0;
      for (int i = 0; i < 64; i++) begin
         ada = 6'(i);
         tick();
      end
      cea = 1'b0; ceb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         adb = 6'($urandom_range(0, 63));
         tick();
      end
      reset = 1'b1;
      tick();
      check("midreset_byp", bus0.dout, 1'b0);
      check("midreset_pipe", bus1.dout, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         adb = 6'($urandom_range(0, 63));
         tick();
         check("kept_byp", bus0.dout, 1'b1);
      end
      check("kept_pipe", bus1.dout, 1'b1);

      // line-buffer sweep
      cea = 1'b1; ceb = 1'b0;
      for (int i = 0; i < 64; i++) begin
         ada = 6'(i); din = i[0];
         tick();
      end
      cea = 1'b0; ceb = 1'b1;
      for (int n = 0; n < 80; n++) begin
         adb = 6'(1 + (n % 36));
         tick();
         check("sweep", bus0.dout, adb[0]);
      end
      ceb = 1'b0;
      for (int n = 0; n < 3; n++) begin
         adb = 6'(2 * n + 2);
         tick();
         check("freeze", bus0.dout, 1'b0);
      end

      // out-of-range on the 36-word build
      cea = 1'b1; ada = 6'd40; din = 1'b1;
      tick();
      cea = 1'b0; ceb = 1'b1; adb = 6'd40;
      tick();
      check("oor_read", bus2.dout, 1'b0);
      check("inrange_40", bus0.dout, 1'b1);
      for (int i = 0; i < 36; i++) begin
         adb = 6'(i);
         tick();
         check("oor_keep", bus2.dout, i[0]);
      end

      // random traffic
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 31) == 0);
         cea = 1'($urandom);
         ceb = 1'($urandom);
         oce = 1'($urandom);
         din = 1'($urandom);
         ada = 6'($urandom_range(0, 63));
         adb = 6'($urandom_range(0, 63));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
